// File: rtl/chip8_alu_sequencer_if.sv
// Shared ALU function type plus the handshake/register/ALU bus between
// the CHIP-8 8XYN sequencer and its environment.
package chip8_alu_pkg;
    typedef enum logic [2:0] {
        ALU_f_NOP,
        ALU_f_OR,
        ALU_f_AND,
        ALU_f_XOR,
        ALU_f_ADD,
        ALU_f_MINUS,
        ALU_f_RSHIFT,
        ALU_f_LSHIFT
    } ALU_f;
endpackage

interface chip8_alu_sequencer_if;
    import chip8_alu_pkg::*;

    logic        start;
    logic [15:0] opcode;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_rdata;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    ALU_f        alu_sel;
    logic [15:0] alu_out;
    logic        alu_carry;

    modport slave (
        input  start, opcode, reg_rdata, alu_out, alu_carry,
        output busy, done, illegal, reg_addr, reg_we, reg_wdata,
               alu_in1, alu_in2, alu_sel
    );

    modport master (
        output start, opcode, reg_rdata, alu_out, alu_carry,
        input  busy, done, illegal, reg_addr, reg_we, reg_wdata,
               alu_in1, alu_in2, alu_sel
    );
endinterface

// File: rtl/chip8_alu_sequencer.sv
// Sequences one CHIP-8 8XYN instruction: read Vx/Vy, run the external ALU,
// write Vx and (for flag-producing ops) VF, then pulse done.
module chip8_alu_sequencer
    import chip8_alu_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    chip8_alu_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RDX, S_RDY, S_CAPY, S_EXEC, S_WBX, S_WBF, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] x_q, y_q, n_q;
    logic [7:0] vx_q, vy_q, res_q, res_d;
    logic       flag_q, flag_d, illegal_q;

    logic        busy, done, illegal, reg_we;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [15:0] alu_in1, alu_in2;
    ALU_f        alu_sel;

    logic       legal, flag_op;
    logic       alu_hi_unused;

    assign legal = (bus.opcode[15:12] == 4'h8) &&
                   ((bus.opcode[3:0] <= 4'h7) || (bus.opcode[3:0] == 4'hE));
    assign flag_op = (n_q inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE});
    assign alu_hi_unused = ^bus.alu_out[15:8];

    // NOTE: every register here has a defined reset value, including operand
    // latches, so an aborted instruction can never leak stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            n_q       <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            res_q     <= '0;
            flag_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from
            // the same pre-edge values regardless of statement order.
            state_q <= state_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            if (state_q == S_IDLE && bus.start) begin
                illegal_q <= ~legal;
                if (legal) begin
                    x_q <= bus.opcode[11:8];
                    y_q <= bus.opcode[7:4];
                    n_q <= bus.opcode[3:0];
                end
            end
            if (state_q == S_RDY)  vx_q <= bus.reg_rdata;
            if (state_q == S_CAPY) vy_q <= bus.reg_rdata;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        illegal   = 1'b0;
        reg_addr  = 4'h0;
        reg_we    = 1'b0;
        reg_wdata = 8'h00;
        alu_sel   = ALU_f_NOP;
        alu_in1   = 16'h0000;
        alu_in2   = 16'h0000;
        res_d     = res_q;
        flag_d    = flag_q;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (bus.start) state_d = legal ? S_RDX : S_DONE;
            end
            S_RDX: begin
                reg_addr = x_q;
                state_d  = S_RDY;
            end
            S_RDY: begin
                reg_addr = y_q;
                state_d  = S_CAPY;
            end
            S_CAPY: state_d = S_EXEC;
            S_EXEC: begin
                alu_in1 = {8'h00, vx_q};
                alu_in2 = {8'h00, vy_q};
                case (n_q)
                    4'h0: begin alu_sel = ALU_f_OR; alu_in1 = 16'h0000; end
                    4'h1: alu_sel = ALU_f_OR;
                    4'h2: alu_sel = ALU_f_AND;
                    4'h3: alu_sel = ALU_f_XOR;
                    4'h4: begin alu_sel = ALU_f_ADD;   flag_d = bus.alu_carry;  end
                    4'h5: begin alu_sel = ALU_f_MINUS; flag_d = ~bus.alu_carry; end
                    4'h6: begin
                        alu_sel = ALU_f_RSHIFT;
                        alu_in2 = 16'h0001;
                        flag_d  = vx_q[0];
                    end
                    4'h7: begin
                        alu_sel = ALU_f_MINUS;
                        alu_in1 = {8'h00, vy_q};
                        alu_in2 = {8'h00, vx_q};
                        flag_d  = ~bus.alu_carry;
                    end
                    4'hE: begin
                        alu_sel = ALU_f_LSHIFT;
                        alu_in2 = 16'h0001;
                        flag_d  = vx_q[7];
                    end
                    default: begin alu_in1 = 16'h0000; alu_in2 = 16'h0000; end
                endcase
                res_d   = bus.alu_out[7:0];
                state_d = S_WBX;
            end
            S_WBX: begin
                reg_we    = 1'b1;
                reg_addr  = x_q;
                reg_wdata = res_q;
                state_d   = flag_op ? S_WBF : S_DONE;
            end
            S_WBF: begin
                // VF is written last so it wins when X is F.
                reg_we    = 1'b1;
                reg_addr  = 4'hF;
                reg_wdata = {7'b0, flag_q};
                state_d   = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = illegal_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.illegal   = illegal;
    assign bus.reg_addr  = reg_addr;
    assign bus.reg_we    = reg_we;
    assign bus.reg_wdata = reg_wdata;
    assign bus.alu_in1   = alu_in1;
    assign bus.alu_in2   = alu_in2;
    assign bus.alu_sel   = alu_sel;

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Scoreboard bench for chip8_alu_sequencer with a byte-ALU model and a
// 16-entry register file having one-cycle read latency.
module tb_chip8_alu_sequencer;
    import chip8_alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chip8_alu_sequencer_if bus();

    chip8_alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic ill; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    logic [7:0] regs [16];
    logic       pre_we = 1'b0;
    logic [3:0] pre_addr = 4'h0;
    logic [7:0] pre_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-oriented ALU: ADD carry out of bit 7, MINUS carry means borrow.
    always_comb begin
        bus.alu_out   = 16'h0000;
        bus.alu_carry = 1'b0;
        case (bus.alu_sel)
            ALU_f_OR:     bus.alu_out = bus.alu_in1 | bus.alu_in2;
            ALU_f_AND:    bus.alu_out = bus.alu_in1 & bus.alu_in2;
            ALU_f_XOR:    bus.alu_out = bus.alu_in1 ^ bus.alu_in2;
            ALU_f_ADD: begin
                bus.alu_out   = bus.alu_in1 + bus.alu_in2;
                bus.alu_carry = ({1'b0, bus.alu_in1} + {1'b0, bus.alu_in2}) > 17'h000FF;
            end
            ALU_f_MINUS: begin
                bus.alu_out   = bus.alu_in1 - bus.alu_in2;
                bus.alu_carry = bus.alu_in1 < bus.alu_in2;
            end
            ALU_f_RSHIFT: bus.alu_out = bus.alu_in1 >> bus.alu_in2;
            ALU_f_LSHIFT: bus.alu_out = bus.alu_in1 << bus.alu_in2;
            default:      bus.alu_out = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (bus.reg_we)  regs[bus.reg_addr] <= bus.reg_wdata;
        else if (pre_we) regs[pre_addr] <= pre_data;
        bus.reg_rdata <= regs[bus.reg_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes or completes.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (bus.reg_we === 1'b1) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none",
                         bus.reg_addr, bus.reg_wdata);
            end else begin
                w = wq.pop_front();
                check("wr_addr", 32'(bus.reg_addr), 32'(w.addr));
                check("wr_data", 32'(bus.reg_wdata), 32'(w.data));
            end
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (dq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                d = dq.pop_front();
                check("done_cycle", 32'(cyc), 32'(d.cyc));
                check("illegal", 32'(bus.illegal), 32'(d.ill));
            end
        end
    end

    task automatic set_reg(input logic [3:0] a, input logic [7:0] v);
        pre_addr = a;
        pre_data = v;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] v);
        wq.push_back('{a, v});
    endtask

    // Issue one opcode; lat is the cycle (edge 0 = start sample) done must appear in.
    task automatic run_op(input logic [15:0] op, input int lat, input logic ill, input bit glitch);
        int  d0;
        int  n;
        bit  seen;
        bus.start  = 1'b1;
        bus.opcode = op;
        dq.push_back('{cyc + lat, ill});
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_running", 32'(bus.busy), 32'd1);
        if (glitch) begin
            @(negedge clk);
            bus.start  = 1'b1;
            bus.opcode = 16'h8121;
            @(negedge clk);
            bus.start  = 1'b0;
        end
        #1;
        seen = (done_cnt != d0);
        n = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            #1;
            seen = (done_cnt != d0);
            n++;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout: op=%h got no done expected done", op);
            dq.delete();
        end
        @(negedge clk);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("writes_drained", 32'(wq.size()), 32'd0);
        wq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    32'(bus.busy), 32'd0);
        check({tag, "_done"},    32'(bus.done), 32'd0);
        check({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        check({tag, "_we"},      32'(bus.reg_we), 32'd0);
        check({tag, "_addr"},    32'(bus.reg_addr), 32'd0);
        check({tag, "_wdata"},   32'(bus.reg_wdata), 32'd0);
        check({tag, "_sel"},     32'(bus.alu_sel), 32'(ALU_f_NOP));
        check({tag, "_in1"},     32'(bus.alu_in1), 32'd0);
        check({tag, "_in2"},     32'(bus.alu_in2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.opcode = 16'h0000;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        for (int i = 0; i < 16; i++) set_reg(4'(i), 8'h00);

        // ADD with carry: B4+B4=168
        set_reg(4'h1, 8'hB4); set_reg(4'h2, 8'hB4);
        exp_wr(4'h1, 8'h68); exp_wr(4'hF, 8'h01);
        run_op(16'h8124, 7, 1'b0, 1'b0);
        check("v1_add", 32'(regs[1]), 32'h68);

        // SUB with borrow, then equal operands
        set_reg(4'h3, 8'h03); set_reg(4'h4, 8'hA5);
        exp_wr(4'h3, 8'h5E); exp_wr(4'hF, 8'h00);
        run_op(16'h8345, 7, 1'b0, 1'b0);
        set_reg(4'h3, 8'hC3); set_reg(4'h4, 8'hC3);
        exp_wr(4'h3, 8'h00); exp_wr(4'hF, 8'h01);
        run_op(16'h8345, 7, 1'b0, 1'b0);

        // Shifts
        set_reg(4'h5, 8'h81);
        exp_wr(4'h5, 8'h02); exp_wr(4'hF, 8'h01);
        run_op(16'h850E, 7, 1'b0, 1'b0);
        set_reg(4'h5, 8'h81);
        exp_wr(4'h5, 8'h40); exp_wr(4'hF, 8'h01);
        run_op(16'h8506, 7, 1'b0, 1'b0);

        // X=F: flag write lands last
        set_reg(4'hF, 8'hFF); set_reg(4'h0, 8'h01);
        exp_wr(4'hF, 8'h00); exp_wr(4'hF, 8'h01);
        run_op(16'h8F04, 7, 1'b0, 1'b0);
        check("vf_final", 32'(regs[15]), 32'h01);

        // OR leaves VF alone
        set_reg(4'h1, 8'hF5); set_reg(4'h2, 8'hFA); set_reg(4'hF, 8'h77);
        exp_wr(4'h1, 8'hFF);
        run_op(16'h8121, 6, 1'b0, 1'b0);
        check("vf_untouched", 32'(regs[15]), 32'h77);

        // SUBN (Vy-Vx) and plain move
        set_reg(4'h0, 8'h10); set_reg(4'h1, 8'h30);
        exp_wr(4'h0, 8'h20); exp_wr(4'hF, 8'h01);
        run_op(16'h8017, 7, 1'b0, 1'b0);
        set_reg(4'h3, 8'h5A);
        exp_wr(4'h2, 8'h5A);
        run_op(16'h8230, 6, 1'b0, 1'b0);

        // Illegal opcodes
        run_op(16'h8128, 1, 1'b1, 1'b0);
        run_op(16'h9120, 1, 1'b1, 1'b0);

        // Start pulsed while busy is ignored
        set_reg(4'h6, 8'h01); set_reg(4'h7, 8'h02);
        exp_wr(4'h6, 8'h03); exp_wr(4'hF, 8'h00);
        run_op(16'h8674, 7, 1'b0, 1'b1);
        repeat (8) @(negedge clk);

        // Reset during EXEC aborts silently
        set_reg(4'h1, 8'hB4); set_reg(4'h2, 8'hB4);
        bus.start  = 1'b1;
        bus.opcode = 16'h8124;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("exec_sel", 32'(bus.alu_sel), 32'(ALU_f_ADD));
        check("exec_in1", 32'(bus.alu_in1), 32'h00B4);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("v1_after_abort", 32'(regs[1]), 32'hB4);

        check("queues_empty", 32'(dq.size() + wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chip8_alu_sequencer.md
CHIP8_ALU_SEQUENCER -- requirements
Module: chip8_alu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to execute opcode; sampled only in IDLE.
REQ-004 SHALL have port opcode, input, 16 bits: 8XYN instruction; sampled together with start.
REQ-005 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-006 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-007 SHALL have port illegal, output, 1 bit: valid with done; high means the opcode was rejected.
REQ-008 SHALL have port reg_addr, output, 4 bits: register-file address for both read and write.
REQ-009 SHALL have port reg_rdata, input, 8 bits: register data, valid one cycle after reg_addr.
REQ-010 SHALL have port reg_we, output, 1 bit: register write enable.
REQ-011 SHALL have port reg_wdata, output, 8 bits: register write data.
REQ-012 SHALL have ports alu_in1 and alu_in2, output, 16 bits each: Chip8_ALU operands.
REQ-013 SHALL have port alu_sel, output, ALU_f: Chip8_ALU function select.
REQ-014 SHALL have ports alu_out, input, 16 bits, and alu_carry, input, 1 bit: Chip8_ALU result and carry.

Function
REQ-015 SHALL implement states IDLE, RDX, RDY, CAPY, EXEC, WBX, WBF and DONE.
REQ-016 IDLE with start=1 and a legal opcode SHALL latch X=opcode[11:8], Y=opcode[7:4], N=opcode[3:0] and go to RDX.
REQ-017 Start while busy=1 SHALL be ignored; opcode is not re-sampled until IDLE.
REQ-018 RDX SHALL drive reg_addr=X.
REQ-019 RDY SHALL drive reg_addr=Y and latch vx_q=reg_rdata.
REQ-020 CAPY SHALL latch vy_q=reg_rdata.
REQ-021 EXEC SHALL drive the ALU combinationally and latch res_q=alu_out[7:0] and flag_q.
REQ-022 ALU operands SHALL be 8-bit register values zero-extended to 16 bits; results SHALL be truncated to [7:0].
REQ-023 Outside EXEC, alu_sel SHALL be ALU_f_NOP and alu_in1=alu_in2=0.
REQ-024 The N mapping SHALL be:
- N=0: sel OR, in1=0, in2=vy; no flag.
- N=1: sel OR, in1=vx, in2=vy; no flag.
- N=2: sel AND, in1=vx, in2=vy; no flag.
- N=3: sel XOR, in1=vx, in2=vy; no flag.
- N=4: sel ADD, in1=vx, in2=vy; flag=alu_carry.
- N=5: sel MINUS, in1=vx, in2=vy; flag=~alu_carry.
- N=6: sel RSHIFT, in1=vx, in2=1; flag=vx_q[0].
- N=7: sel MINUS, in1=vy, in2=vx; flag=~alu_carry.
- N=E: sel LSHIFT, in1=vx, in2=1; flag=vx_q[7].
REQ-025 WBX SHALL assert reg_we for exactly one cycle with reg_addr=X and reg_wdata=res_q.
REQ-026 WBF SHALL be entered only for N in {4,5,6,7,E}; it SHALL assert reg_we with reg_addr=4'hF and reg_wdata={7'b0,flag_q}.
REQ-027 Because WBF follows WBX, when X=F the flag value SHALL be the final VF contents.
REQ-028 N in {1,2,3} SHALL leave VF unmodified.
REQ-029 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-030 Latency, with start sampled at edge 0: done SHALL be high in cycle 7 for flag ops and in cycle 6 otherwise.
REQ-031 An illegal opcode is opcode[15:12]!=4'h8 or N not in {0-7,E}.
REQ-032 IDLE with start=1 and an illegal opcode SHALL go directly to DONE with illegal=1, no register access, and done in cycle 1.
REQ-033 illegal SHALL be 0 for every legal completion.
REQ-034 reg_we SHALL be 0 in every state other than WBX and WBF.
REQ-035 reg_addr SHALL be 0 in IDLE and DONE.

Reset
REQ-036 reset=1 SHALL on the next edge force IDLE and set busy=0, done=0, illegal=0, reg_we=0, reg_addr=0, reg_wdata=0, alu_sel=ALU_f_NOP and alu_in1=alu_in2=0.
REQ-037 reset=1 SHALL clear vx_q, vy_q, res_q and flag_q to 0.
REQ-038 Reset mid-operation SHALL abort with no done pulse.
REQ-039 A reset asserted during WBX SHALL prevent WBF; Vx may then be updated while VF is not, and this is accepted behaviour.

Verification
REQ-040 SHALL test: V1=B4, V2=B4, opcode 8124 -> write V1=68 then VF=01; done in cycle 7; illegal=0.
REQ-041 SHALL test: V3=03, V4=A5, opcode 8345 -> V3=5E, VF=00; with V3=V4=C3 -> V3=00, VF=01.
REQ-042 SHALL test: V5=81, opcode 850E -> V5=02, VF=01; opcode 8506 -> V5=40, VF=01.
REQ-043 SHALL test: VF=FF, V0=01, opcode 8F04 -> VF=01 after both writes.
REQ-044 SHALL test: V1=F5, V2=FA, opcode 8121 -> V1=FF, exactly one reg_we, VF untouched, done in cycle 6.
REQ-045 SHALL test: opcode 8128 or 9120 -> done in cycle 1 with illegal=1 and no reg_we.
REQ-046 SHALL test: start pulsed during busy is ignored.
REQ-047 SHALL test: reset in EXEC returns all outputs to reset values next cycle with no done pulse.
